// File: rtl/pc_gen.sv
// Fetch program-counter generator with flush/stall/branch redirect and a
// circular return-address stack for call/return prediction.
module pc_gen #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        INC       = 4,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              call_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] return_addr_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              ras_empty,
  output logic              ras_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] pc_next;
  logic [PTR_W-1:0]  top_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;

  // Only bit 0 of the stall vector concerns the pc stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  always_comb begin
    pc_next  = pc;
    top_next = top;
    cnt_next = cnt;
    wr_en    = 1'b0;
    wr_idx   = top;
    if (!ce) begin
      pc_next = RESET_VEC;
    end else if (flush_i) begin
      pc_next  = flush_target_i;
      cnt_next = '0;
    end else if (stall[0]) begin
      pc_next = pc;
    end else if (branch_flag_i) begin
      if (ret_i && (cnt != '0)) begin
        pc_next = ras[top];
        // Call+return replaces the popped top in place, so depth is unchanged.
        if (call_i) begin
          wr_en  = 1'b1;
          wr_idx = top;
        end else begin
          top_next = top - PTR_W'(1);
          cnt_next = cnt - CNT_W'(1);
        end
      end else begin
        pc_next = branch_target_address_i;
        if (call_i) begin
          wr_en    = 1'b1;
          wr_idx   = top + PTR_W'(1);
          top_next = top + PTR_W'(1);
          if (cnt != FULL_CNT)
            cnt_next = cnt + CNT_W'(1);
        end
      end
    end else begin
      pc_next = pc + ADDR_W'(INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_VEC;
      ce        <= 1'b0;
      top       <= '0;
      cnt       <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
    end else begin
      pc        <= pc_next;
      ce        <= 1'b1;
      top       <= top_next;
      cnt       <= cnt_next;
      ras_empty <= (cnt_next == '0);
      ras_full  <= (cnt_next == FULL_CNT);
    end
  end

  // Stack storage is never reset; the entry count alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en)
      ras[wr_idx] <= return_addr_i;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: reset, stall, flush, RAS behaviour
// and pc wrap-around at two address widths.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_target_i = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_address_i = '0;
  logic        call_i = 1'b0;
  logic        ret_i = 1'b0;
  logic [31:0] return_addr_i = '0;
  logic [31:0] pc;
  logic        ce;
  logic        ras_empty;
  logic        ras_full;

  logic        flush16 = 1'b0;
  logic [15:0] flush_target16 = '0;
  logic [15:0] pc16;
  logic        ce16;
  logic        ras_empty16;
  logic        ras_full16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_i(flush_i),
    .flush_target_i(flush_target_i), .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i), .call_i(call_i),
    .ret_i(ret_i), .return_addr_i(return_addr_i), .pc(pc), .ce(ce),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  pc_gen #(.ADDR_W(16)) dut16 (
    .clk(clk), .rst(rst), .stall(6'd0), .flush_i(flush16),
    .flush_target_i(flush_target16), .branch_flag_i(1'b0),
    .branch_target_address_i(16'h0), .call_i(1'b0), .ret_i(1'b0),
    .return_addr_i(16'h0), .pc(pc16), .ce(ce16),
    .ras_empty(ras_empty16), .ras_full(ras_full16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = '0; flush_i = 0; flush_target_i = '0; branch_flag_i = 0;
    branch_target_address_i = '0; call_i = 0; ret_i = 0; return_addr_i = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    rst = 1'b1;
    step();
    checks++;
    if (pc !== 32'h0 || ce !== 1'b0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: pc=%h ce=%b empty=%b full=%b, expected pc=0 ce=0 empty=1 full=0",
               pc, ce, ras_empty, ras_full);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pc !== exp_pc[i] || ce !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_seq[%0d]: pc=%h ce=%b, expected pc=%h ce=1", i, pc, ce, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    step();
    checks++;
    if (pc !== 32'h10) begin
      errors++;
      $display("[TB] FAIL stall_pre: pc=%h expected 00000010", pc);
    end
    stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h200;
    call_i = 1; return_addr_i = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'h10 || ras_empty !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: pc=%h empty=%b, expected pc=00000010 empty=1", i, pc, ras_empty);
      end
    end
    clear_inputs();
    step();
    checks++;
    if (pc !== 32'h14) begin
      errors++;
      $display("[TB] FAIL stall_resume: pc=%h expected 00000014", pc);
    end
  endtask

  task automatic test_flush();
    branch_flag_i = 1; call_i = 1; branch_target_address_i = 32'h300; return_addr_i = 32'h18;
    step();
    checks++;
    if (pc !== 32'h300 || ras_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_prepush: pc=%h empty=%b, expected pc=00000300 empty=0", pc, ras_empty);
    end
    clear_inputs();
    flush_i = 1; flush_target_i = 32'h100; stall = 6'b000001; branch_flag_i = 1; ret_i = 1;
    branch_target_address_i = 32'h444;
    step();
    checks++;
    if (pc !== 32'h100 || ras_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_redirect: pc=%h empty=%b, expected pc=00000100 empty=1", pc, ras_empty);
    end
    clear_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] pushes [5] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
    logic [31:0] pops   [5] = '{32'hE0, 32'hD0, 32'hC0, 32'hB0, 32'h500};
    for (int i = 0; i < 5; i++) begin
      branch_flag_i = 1; call_i = 1; return_addr_i = pushes[i];
      branch_target_address_i = 32'h1000 + 32'(i) * 32'h10;
      step();
      checks++;
      if (pc !== 32'h1000 + 32'(i) * 32'h10 || ras_full !== (i >= 3)) begin
        errors++;
        $display("[TB] FAIL ras_push[%0d]: pc=%h full=%b, expected pc=%h full=%b",
                 i, pc, ras_full, 32'h1000 + 32'(i) * 32'h10, (i >= 3));
      end
    end
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      branch_flag_i = 1; ret_i = 1; branch_target_address_i = 32'h500;
      step();
      checks++;
      if (pc !== pops[i] || ras_full !== 1'b0 || ras_empty !== (i >= 3)) begin
        errors++;
        $display("[TB] FAIL ras_pop[%0d]: pc=%h full=%b empty=%b, expected pc=%h full=0 empty=%b",
                 i, pc, ras_full, ras_empty, pops[i], (i >= 3));
      end
    end
    clear_inputs();
  endtask

  task automatic test_call_ret();
    branch_flag_i = 1; call_i = 1; return_addr_i = 32'h40; branch_target_address_i = 32'h600;
    step();
    branch_flag_i = 1; call_i = 1; ret_i = 1; return_addr_i = 32'h80; branch_target_address_i = 32'h700;
    step();
    checks++;
    if (pc !== 32'h40 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL callret_pop: pc=%h empty=%b full=%b, expected pc=00000040 empty=0 full=0",
               pc, ras_empty, ras_full);
    end
    clear_inputs();
    branch_flag_i = 1; ret_i = 1; branch_target_address_i = 32'h800;
    step();
    checks++;
    if (pc !== 32'h80 || ras_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL callret_next: pc=%h empty=%b, expected pc=00000080 empty=1", pc, ras_empty);
    end
    branch_target_address_i = 32'h900;
    step();
    checks++;
    if (pc !== 32'h900 || ras_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ret_empty: pc=%h empty=%b, expected pc=00000900 empty=1", pc, ras_empty);
    end
    call_i = 1; return_addr_i = 32'hB0; branch_target_address_i = 32'hA00;
    step();
    checks++;
    if (pc !== 32'hA00 || ras_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL callret_empty: pc=%h empty=%b, expected pc=00000a00 empty=0", pc, ras_empty);
    end
    clear_inputs();
    call_i = 1; ret_i = 1; return_addr_i = 32'hCC;
    step();
    checks++;
    if (pc !== 32'hA04 || ras_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unqualified: pc=%h empty=%b, expected pc=00000a04 empty=0", pc, ras_empty);
    end
    clear_inputs();
    branch_flag_i = 1; ret_i = 1; branch_target_address_i = 32'hF00;
    step();
    checks++;
    if (pc !== 32'hB0 || ras_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL callret_empty_pop: pc=%h empty=%b, expected pc=000000b0 empty=1", pc, ras_empty);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    branch_flag_i = 1; call_i = 1; return_addr_i = 32'h55; branch_target_address_i = 32'h2000;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0 || ce !== 1'b0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: pc=%h ce=%b empty=%b full=%b, expected pc=0 ce=0 empty=1 full=0",
               pc, ce, ras_empty, ras_full);
    end
    clear_inputs();
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (pc !== 32'h4 || ce !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_restart: pc=%h ce=%b, expected pc=00000004 ce=1", pc, ce);
    end
  endtask

  task automatic test_wrap();
    flush_i = 1; flush_target_i = 32'hFFFF_FFFC;
    flush16 = 1; flush_target16 = 16'hFFFC;
    step();
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc16 !== 16'hFFFC) begin
      errors++;
      $display("[TB] FAIL wrap_load: pc=%h pc16=%h, expected pc=fffffffc pc16=fffc", pc, pc16);
    end
    clear_inputs();
    flush16 = 0;
    step();
    checks++;
    if (pc !== 32'h0 || pc16 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL wrap_inc: pc=%h pc16=%h, expected pc=00000000 pc16=0000", pc, pc16);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_ras_overflow();
    test_call_ret();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
